// File: rtl/ac_alu_pkg.sv
// Shared definitions for the accumulator ALU: operation codes, FSM states, default width.
package ac_alu_pkg;

    localparam int AC_WIDTH_DEF = 16;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LOAD = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_MUL  = 4'd4,
        OP_INC  = 4'd5,
        OP_DEC  = 4'd6,
        OP_CLR  = 4'd7
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one step per clock, MUL_CYCLES steps after start.
// done is high during the final step; product then carries the completed low WIDTH bits.
module shift_add_mul #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_pp;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_pp_nxt;
    logic             w_last;

    // LSB-first: multiplicand shifts left, multiplier right; bits above WIDTH fall away.
    assign w_addend = r_mplier[0] ? r_mcand : '0;
    assign w_pp_nxt = r_pp + w_addend;
    assign w_last   = r_busy && (r_cnt == CW'(MUL_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_pp     <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= multiplicand;
            r_mplier <= multiplier;
            r_pp     <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_pp     <= w_pp_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = w_last;
    assign product = w_pp_nxt;

endmodule

// File: rtl/ac_alu.sv
// Accumulator ALU: single-cycle ops update AC on the accepting edge; MUL runs MUL_CYCLES more edges.
// Requests seen while busy are dropped, not queued; done pulses one cycle after each completion.
module ac_alu
    import ac_alu_pkg::*;
#(
    parameter int WIDTH      = AC_WIDTH_DEF,
    parameter int MUL_CYCLES = AC_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             op_valid,
    input  logic [3:0]       op_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ac_out,
    output logic             z_flag
);

    state_e           r_state;
    logic [WIDTH-1:0] r_ac;
    logic             r_done;

    state_e           w_state_nxt;
    logic             w_done_nxt;
    logic             w_ac_we;
    logic [WIDTH-1:0] w_ac_nxt;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_busy;
    logic             w_accept;
    logic             w_mul_start;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;

    assign w_busy   = (r_state == S_MUL);
    assign w_accept = op_valid && !w_busy && !w_mul_busy;

    always_comb begin
        w_alu_res = r_ac;
        case (op_code)
            OP_LOAD: w_alu_res = bus_in;
            OP_ADD:  w_alu_res = r_ac + bus_in;
            OP_SUB:  w_alu_res = r_ac - bus_in;
            OP_INC:  w_alu_res = r_ac + WIDTH'(1);
            OP_DEC:  w_alu_res = r_ac - WIDTH'(1);
            OP_CLR:  w_alu_res = '0;
            default: w_alu_res = r_ac;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_ac_we     = 1'b0;
        w_ac_nxt    = w_alu_res;
        w_mul_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (op_code == OP_MUL) begin
                        w_mul_start = 1'b1;
                        w_state_nxt = S_MUL;
                    end else begin
                        w_ac_we    = 1'b1;
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (w_mul_done) begin
                    w_ac_we     = 1'b1;
                    w_ac_nxt    = w_mul_product;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ac    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_ac_we) begin
                r_ac <= w_ac_nxt;
            end
        end
    end

    shift_add_mul #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk          (clk),
        .rst          (rst),
        .start        (w_mul_start),
        .multiplicand (r_ac),
        .multiplier   (bus_in),
        .busy         (w_mul_busy),
        .done         (w_mul_done),
        .product      (w_mul_product)
    );

    assign busy   = w_busy;
    assign done   = r_done;
    assign ac_out = r_ac;
    assign z_flag = (r_ac == '0);

endmodule

// File: tb/tb_ac_alu.sv
// Bench for ac_alu: expected AC values are queued when an op is driven and popped when done is seen.
module tb_ac_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_in;
    logic        op_valid;
    logic [3:0]  op_code;
    logic        busy;
    logic        done;
    logic [15:0] ac_out;
    logic        z_flag;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_ac = 16'h0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    ac_alu dut (
        .clk      (clk),
        .rst      (rst),
        .bus_in   (bus_in),
        .op_valid (op_valid),
        .op_code  (op_code),
        .busy     (busy),
        .done     (done),
        .ac_out   (ac_out),
        .z_flag   (z_flag)
    );

    function automatic logic [15:0] model(input logic [3:0] op, input logic [15:0] b, input logic [15:0] a);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        case (op)
            4'd1:    return b;
            4'd2:    return a + b;
            4'd3:    return a - b;
            4'd4:    return p[15:0];
            4'd5:    return a + 16'd1;
            4'd6:    return a - 16'd1;
            4'd7:    return 16'h0;
            default: return a;
        endcase
    endfunction

    // Drives one request for one edge; returns 1 ns after that edge.
    task automatic issue(input logic [3:0] op, input logic [15:0] b, input bit push);
        logic [15:0] e;
        e = model(op, b, model_ac);
        if (push) begin
            sb.push_back(e);
            model_ac = e;
        end
        op_valid = 1'b1;
        op_code  = op;
        bus_in   = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_code  = 4'd0;
        bus_in   = 16'($urandom);
    endtask

    task automatic pop_exp(output logic [15:0] e, output bit ok);
        ok = (sb.size() != 0);
        e  = ok ? sb.pop_front() : 16'hxxxx;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        op_valid = 1'b1;
        op_code  = 4'd1;
        bus_in   = 16'h1234;
        step(2);
        op_valid = 1'b0;
        checks++; if (ac_out !== 16'h0) begin errors++; $display("FAIL reset_ac got %h exp 0000", ac_out); end
        checks++; if (z_flag !== 1'b1) begin errors++; $display("FAIL reset_z got %b exp 1", z_flag); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        rst = 1'b0;
        model_ac = 16'h0;
        sb.delete();
        step(1);
        checks++; if (ac_out !== 16'h0 || done !== 1'b0) begin errors++; $display("FAIL reset_prio got ac %h done %b exp 0000 0", ac_out, done); end
    endtask

    task automatic test_single_ops;
        logic [3:0]  ops [8] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd12, 4'd2, 4'd15, 4'd7};
        logic [15:0] bs  [8] = '{16'h00FF, 16'h0001, 16'h0101, 16'hAAAA, 16'h5555, 16'h0102, 16'h7777, 16'h9999};
        logic [15:0] e;
        bit          ok;
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], bs[i], 1'b1);
            pop_exp(e, ok);
            checks++; if (done !== 1'b1 || !ok) begin errors++; $display("FAIL single_done[%0d] got %b exp 1", i, done); end
            checks++; if (ac_out !== e) begin errors++; $display("FAIL single_ac[%0d] got %h exp %h", i, ac_out, e); end
            checks++; if (z_flag !== (e == 16'h0)) begin errors++; $display("FAIL single_z[%0d] got %b exp %b", i, z_flag, (e == 16'h0)); end
            if (i == 1) begin
                checks++; if (ac_out !== 16'h0100) begin errors++; $display("FAIL load_add got %h exp 0100", ac_out); end
            end
        end
        step(1);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b exp 0", done); end
    endtask

    task automatic test_wrap;
        logic [15:0] exp_v [3] = '{16'h0000, 16'hFFFF, 16'h0000};
        logic [3:0]  ops   [3] = '{4'd1, 4'd6, 4'd5};
        logic [15:0] e;
        bit          ok;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], 16'h0000, 1'b1);
            pop_exp(e, ok);
            checks++; if (!ok || done !== 1'b1 || ac_out !== e || e !== exp_v[i]) begin
                errors++; $display("FAIL wrap[%0d] got %h done %b exp %h", i, ac_out, done, exp_v[i]);
            end
        end
        checks++; if (z_flag !== 1'b1) begin errors++; $display("FAIL wrap_z got %b exp 1", z_flag); end
    endtask

    task automatic test_mul;
        logic [15:0] e;
        bit          ok;
        int          busy_cnt = 0;
        bit          held = 1'b1;
        bit          overlap = 1'b0;
        int          extra_done = 0;
        issue(4'd1, 16'h0123, 1'b1);
        pop_exp(e, ok);
        issue(4'd4, 16'h0010, 1'b1);
        for (int c = 0; c < 40 && done !== 1'b1; c++) begin
            if (busy === 1'b1) busy_cnt++;
            if (ac_out !== 16'h0123) held = 1'b0;
            op_valid = (c == 5);
            op_code  = 4'd2;
            bus_in   = (c == 5) ? 16'h0005 : 16'($urandom);
            @(posedge clk);
            #1;
        end
        op_valid = 1'b0;
        if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
        pop_exp(e, ok);
        checks++; if (done !== 1'b1 || !ok) begin errors++; $display("FAIL mul_done got %b exp 1", done); end
        checks++; if (busy_cnt != 16) begin errors++; $display("FAIL mul_busy_cycles got %0d exp 16", busy_cnt); end
        checks++; if (!held) begin errors++; $display("FAIL mul_ac_hold got 0 exp 1"); end
        checks++; if (overlap) begin errors++; $display("FAIL mul_busy_done_overlap got 1 exp 0"); end
        checks++; if (ac_out !== e || e !== 16'h1230) begin errors++; $display("FAIL mul_result got %h exp 1230", ac_out); end
        for (int c = 0; c < 5; c++) begin
            step(1);
            if (done === 1'b1) extra_done++;
        end
        checks++; if (extra_done != 0 || ac_out !== 16'h1230) begin
            errors++; $display("FAIL mul_drop got %0d dones ac %h exp 0 dones ac 1230", extra_done, ac_out);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] e;
        bit          ok;
        issue(4'd1, 16'h8000, 1'b1);
        pop_exp(e, ok);
        issue(4'd4, 16'h0002, 1'b1);
        for (int c = 0; c < 40 && done !== 1'b1; c++) step(1);
        pop_exp(e, ok);
        checks++; if (done !== 1'b1 || !ok || busy !== 1'b0 || ac_out !== e || e !== 16'h0000) begin
            errors++; $display("FAIL mul_trunc got ac %h done %b busy %b exp 0000 1 0", ac_out, done, busy);
        end
        issue(4'd5, 16'h0000, 1'b1);
        pop_exp(e, ok);
        checks++; if (done !== 1'b1 || !ok || ac_out !== e || e !== 16'h0001) begin
            errors++; $display("FAIL b2b_inc got ac %h done %b exp 0001 1", ac_out, done);
        end
    endtask

    task automatic test_reset_mid_mul;
        logic [15:0] e;
        bit          ok;
        int          dones = 0;
        issue(4'd1, 16'h0007, 1'b1);
        pop_exp(e, ok);
        issue(4'd4, 16'h0003, 1'b0);
        step(8);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        model_ac = 16'h0;
        checks++; if (ac_out !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || z_flag !== 1'b1) begin
            errors++; $display("FAIL rst_mid got ac %h busy %b done %b z %b exp 0000 0 0 1", ac_out, busy, done, z_flag);
        end
        issue(4'd1, 16'h0042, 1'b1);
        pop_exp(e, ok);
        checks++; if (done !== 1'b1 || !ok || ac_out !== e || e !== 16'h0042) begin
            errors++; $display("FAIL rst_mid_load got ac %h done %b exp 0042 1", ac_out, done);
        end
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (done === 1'b1) dones++;
        end
        checks++; if (dones != 0 || ac_out !== 16'h0042) begin
            errors++; $display("FAIL rst_mid_abort got %0d dones ac %h exp 0 dones ac 0042", dones, ac_out);
        end
    endtask

    initial begin
        rst      = 1'b0;
        op_valid = 1'b0;
        op_code  = 4'd0;
        bus_in   = 16'h0;
        #1;
        test_reset;
        test_single_ops;
        test_wrap;
        test_mul;
        test_back_to_back;
        test_reset_mid_mul;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
